// File: rtl/bs_s00_axi_regs.sv
// bs_s00_axi_regs
//   AXI4-Lite slave that holds four 32-bit control registers for the bs
//   block. It accepts one outstanding write and one outstanding read, and it
//   supports full backpressure on the B and R channels.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN    : clock (rising edge) and asynchronous
//                                  active-low reset
//   S_AXI_AW* / S_AXI_W*         : write address and write data channels.
//                                  They are captured independently.
//   S_AXI_B*                     : write response, always OKAY
//   S_AXI_AR* / S_AXI_R*         : read address and read data channels,
//                                  always OKAY
//   regs_o                       : {reg3, reg2, reg1, reg0}, with reg0 in [31:0]
//   wr_pulse_o                   : one-cycle pulse per register when a write
//                                  commits
//
// Handshake semantics: a transfer happens on a rising edge where VALID and
// READY are both 1. A source holds VALID and its payload stable until that
// edge. Every READY and VALID driven here is a flop, so a READY that
// completes a handshake drops on the following cycle.
module bs_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [3:0]                      wr_pulse_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

  // Write-path state
  logic          r_awready, r_wready, r_bvalid;
  logic          r_aw_held, r_w_held;
  logic [AW-1:0] r_aw_addr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic [3:0]    r_wr_pulse;
  logic [DW-1:0] r_regs [4];

  // Read-path state
  logic          r_arready, r_rvalid;
  logic [DW-1:0] r_rdata;

  logic          w_aw_hs, w_w_hs, w_commit;
  logic          w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt;
  logic          w_ar_hs, w_r_hs, w_rvalid_nxt;
  logic [1:0]    w_wr_idx, w_rd_idx;

  // The protection bits and the byte-offset address bits carry no meaning
  // for word-wide registers.
  logic          w_unused_ok;
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    w_aw_hs       = S_AXI_AWVALID && r_awready;
    w_w_hs        = S_AXI_WVALID && r_wready;
    // A write commits as soon as both halves have been captured. Neither
    // half can be accepted while both are held, because each READY is low
    // then.
    w_commit      = r_aw_held && r_w_held;
    w_aw_held_nxt = w_commit ? 1'b0 : (r_aw_held || w_aw_hs);
    w_w_held_nxt  = w_commit ? 1'b0 : (r_w_held || w_w_hs);
    w_bvalid_nxt  = w_commit || (r_bvalid && !S_AXI_BREADY);
    w_wr_idx      = r_aw_addr[3:2];

    w_ar_hs       = S_AXI_ARVALID && r_arready;
    w_r_hs        = r_rvalid && S_AXI_RREADY;
    w_rvalid_nxt  = w_ar_hs || (r_rvalid && !w_r_hs);
    w_rd_idx      = S_AXI_ARADDR[3:2];
  end

  // Write channel control and the register file
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_addr  <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
      r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
      if (w_aw_hs) r_aw_addr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_wr_pulse[w_wr_idx] <= 1'b1;
        for (int k = 0; k < SW; k++) begin
          if (r_wstrb[k]) r_regs[w_wr_idx][8*k +: 8] <= r_wdata[8*k +: 8];
        end
      end
    end
  end

  // Read channel. RDATA samples the register file before any commit on the
  // same edge, so a colliding read returns the pre-write value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= !w_rvalid_nxt;
      if (w_ar_hs) r_rdata <= r_regs[w_rd_idx];
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign regs_o        = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
  assign wr_pulse_o    = r_wr_pulse;

endmodule

// File: tb/tb_bs_s00_axi_regs.sv
// Testbench for bs_s00_axi_regs.
//
// The bench keeps a reference register model and two expected queues:
//   - one for read data, pushed at the AR handshake;
//   - one for write pulses, pushed when a write is driven.
// Inputs are driven, and outputs sampled, on the falling clock edge.
module tb_bs_s00_axi_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] regs_o;
  logic [3:0]   wr_pulse_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_regs [4];
  logic [31:0] exp_q[$];
  logic [3:0]  pulse_q[$];

  bs_s00_axi_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The pulse monitor also catches pulses that last more than one cycle and
  // pulses that nobody expected.
  always @(negedge clk) begin
    if (rst_n && wr_pulse_o != 4'b0000) begin
      if (pulse_q.size() == 0) check("pulse_unexpected", {124'b0, wr_pulse_o}, 128'b0);
      else check("wr_pulse", {124'b0, wr_pulse_o}, {124'b0, pulse_q.pop_front()});
    end
  end

  function automatic void model_wr(input logic [3:0] addr, input logic [31:0] data,
                                   input logic [3:0] strb);
    for (int k = 0; k < 4; k++)
      if (strb[k]) m_regs[addr[3:2]][8*k +: 8] = data[8*k +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_b(input int bhold);
    int cnt = 0;
    while (!bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    check("bvalid", {127'b0, bvalid}, 128'd1);
    check("bresp", {126'b0, bresp}, 128'd0);
    repeat (bhold) begin
      @(negedge clk);
      check("bvalid_hold", {127'b0, bvalid}, 128'd1);
      check("awready_blocked", {127'b0, awready}, 128'd0);
      check("wready_blocked", {127'b0, wready}, 128'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_clear", {127'b0, bvalid}, 128'd0);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int bhold);
    int cnt = 0;
    logic a, w;
    model_wr(addr, data, strb);
    pulse_q.push_back(4'b0001 << addr[3:2]);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && cnt < 50) begin
      a = awvalid && awready;
      w = wvalid && wready;
      @(negedge clk);
      if (a) awvalid = 1'b0;
      if (w) wvalid = 1'b0;
      cnt++;
    end
    check("wr_accept", {126'b0, awvalid, wvalid}, 128'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(bhold);
  endtask

  task automatic rd_addr(input logic [3:0] addr);
    int cnt = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && cnt < 50) begin @(negedge clk); cnt++; end
    check("ar_accept", {127'b0, arready}, 128'd1);
    exp_q.push_back(m_regs[addr[3:2]]);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic rd_data(input int hold);
    int cnt = 0;
    logic [31:0] first;
    while (!rvalid && cnt < 50) begin @(negedge clk); cnt++; end
    check("rvalid", {127'b0, rvalid}, 128'd1);
    first = rdata;
    repeat (hold) begin
      @(negedge clk);
      check("rvalid_hold", {127'b0, rvalid}, 128'd1);
      check("rdata_stable", {96'b0, rdata}, {96'b0, first});
    end
    check("rresp", {126'b0, rresp}, 128'd0);
    if (exp_q.size() == 0) check("rdata_unexpected", {96'b0, rdata}, 128'd0);
    else check("rdata", {96'b0, rdata}, {96'b0, exp_q.pop_front()});
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_clear", {127'b0, rvalid}, 128'd0);
  endtask

  task automatic do_read(input logic [3:0] addr, input int hold);
    rd_addr(addr);
    rd_data(hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [31:0] rd_exp;
    awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", {127'b0, awready}, 128'd0);
    check("rst_wready", {127'b0, wready}, 128'd0);
    check("rst_arready", {127'b0, arready}, 128'd0);
    check("rst_bvalid", {127'b0, bvalid}, 128'd0);
    check("rst_rvalid", {127'b0, rvalid}, 128'd0);
    check("rst_rdata", {96'b0, rdata}, 128'd0);
    check("rst_regs", regs_o, 128'd0);
    check("rst_pulse", {124'b0, wr_pulse_o}, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", {125'b0, awready, wready, arready}, 128'd7);

    // Sequential writes to all four registers, then read them back
    for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0);
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

    // Byte strobes
    do_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0);
    do_write(4'h4, 32'h1234_5678, 4'b0101, 0);
    check("strobe_model", {96'b0, m_regs[1]}, {96'b0, 32'hFF34_FF78});
    do_read(4'h4, 0);

    // A zero strobe still pulses and responds, but changes no data
    do_write(4'h0, 32'hDEAD_BEEF, 4'b0000, 0);
    do_read(4'h0, 0);

    // W arrives three cycles before AW
    model_wr(4'h8, 32'hA5A5_A5A5, 4'hF);
    pulse_q.push_back(4'b0100);
    wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    cnt = 0;
    while (!wready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    wvalid = 1'b0;
    check("wready_drop", {127'b0, wready}, 128'd0);
    repeat (3) begin
      @(negedge clk);
      check("w_early_wready", {127'b0, wready}, 128'd0);
      check("w_early_bvalid", {127'b0, bvalid}, 128'd0);
    end
    awaddr = 4'h8; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    awvalid = 1'b0;
    check("b_not_early", {127'b0, bvalid}, 128'd0);
    @(negedge clk);
    check("b_after_commit", {127'b0, bvalid}, 128'd1);
    check("reg2_commit", {96'b0, regs_o[95:64]}, {96'b0, 32'hA5A5_A5A5});
    wait_b(0);

    // B backpressure: BREADY is held low for 5 cycles
    do_write(4'hC, 32'h0BAD_CAFE, 4'hF, 5);
    do_write(4'hC, 32'h0000_0044, 4'hF, 0);
    do_read(4'hC, 0);

    // R backpressure, with a write to the same register while R is pending
    rd_addr(4'h8);
    do_write(4'h8, 32'h5A5A_0000, 4'hF, 0);
    rd_data(4);
    do_read(4'h8, 0);

    // Reset lands between the AW and W handshakes of a write to 0xC
    awaddr = 4'hC; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    awvalid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_regs", regs_o, 128'd0);
    repeat (5) begin
      @(negedge clk);
      check("rst_mid_no_b", {127'b0, bvalid}, 128'd0);
    end
    wdata = 32'h1111_2222; wvalid = 1'b1;
    repeat (3) @(negedge clk);
    wvalid = 1'b0;
    check("rst_mid_no_commit", {127'b0, bvalid}, 128'd0);
    // That orphan W is now held inside the DUT. The next write supplies a
    // fresh W, which is accepted only after this held data has committed.
    // The simpler route is a second reset to discard it.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_write(4'hC, 32'hCAFE_F00D, 4'hF, 0);
    do_read(4'hC, 0);

    // Random traffic
    for (int i = 0; i < 8; i++) begin
      do_write(4'($urandom_range(0, 3) * 4), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 2));
      do_read(4'($urandom_range(0, 3) * 4), $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    rd_exp = m_regs[0];
    check("final_regs", regs_o, {m_regs[3], m_regs[2], m_regs[1], rd_exp});
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("pulse_q_empty", 128'(pulse_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
